bin_to_bcd_seq: RTL



---
 rtl/bin_to_bcd_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   Each clock applies the digit adjust and shifts one binary bit in, so a
//   conversion takes WIDTH clocks after the start is accepted.
//
// Parameters
//   WIDTH   binary operand width (>= 4)
//   DIGITS  number of BCD digits produced (bcd is 4*DIGITS bits)
//
// Ports
//   clk    system clock, rising edge
//   rst    synchronous reset, active-high
//   start  conversion request, only acted on while idle
//   bin    binary operand, captured when start is accepted
//   busy   high while a conversion is in progress
//   done   one-cycle pulse when a new result lands on bcd
//   bcd    result, digit 0 in bits [3:0]; holds until the next completion
//   ovf    (only with BIN_TO_BCD_SEQ_OVF_EN) operand did not fit in DIGITS
//          digits; updated together with bcd
//
// Optional feature macro: BIN_TO_BCD_SEQ_OVF_EN
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; bcd holds the last result
// CONV  | one adjust+shift per clock, WIDTH clocks in total
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BIN_TO_BCD_SEQ_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [BW-1:0]   acc_adj;
    logic [BW-1:0]   acc_shift;
    logic            out_bit;

`ifdef BIN_TO_BCD_SEQ_OVF_EN
    logic            flag_q, flag_d;
    logic            ovf_q, ovf_d;
`endif

    // Add-3 on every digit >= 5 so the following doubling carries into the
    // next digit exactly when the digit would exceed 9.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // The bit leaving the top digit is a carry worth 10^DIGITS; dropping it
    // leaves the result modulo 10^DIGITS.
    assign acc_shift = {acc_adj[BW-2:0], sreg_q[WIDTH-1]};
    assign out_bit   = acc_adj[BW-1];

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BIN_TO_BCD_SEQ_OVF_EN
        flag_d  = flag_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sreg_d  = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
`ifdef BIN_TO_BCD_SEQ_OVF_EN
                    flag_d  = 1'b0;
`endif
                end
            end
            CONV: begin
                acc_d  = acc_shift;
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q + CW'(1);
`ifdef BIN_TO_BCD_SEQ_OVF_EN
                flag_d = flag_q | out_bit;
`endif
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bcd_d   = acc_shift;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef BIN_TO_BCD_SEQ_OVF_EN
                    ovf_d   = flag_q | out_bit;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BIN_TO_BCD_SEQ_OVF_EN
            flag_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BIN_TO_BCD_SEQ_OVF_EN
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
`ifdef BIN_TO_BCD_SEQ_OVF_EN
    assign ovf  = ovf_q;
`endif

    // Unused in the default build.
    logic unused_out_bit;
    assign unused_out_bit = out_bit;

endmodule
